// File: rtl/platform_pio_gpio_if.sv
// Avalon-MM slave bus bundle for the platform GPIO block.
// The master drives address, strobes and write data; the slave returns read data.
interface platform_pio_gpio_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/platform_pio_gpio.sv
// Parametrised Avalon-MM GPIO: output register with set/clear aliases, synchronised
// inputs with per-bit edge capture and a maskable level interrupt.
module platform_pio_gpio #(
  parameter int          WIDTH       = 8,
  parameter logic [31:0] RESET_VALUE = 32'h0,
  parameter int          EDGE_TYPE   = 0,
  parameter int          SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  platform_pio_gpio_if.slave   bus,
  input  logic [WIDTH-1:0]     in_port,
  output logic [WIDTH-1:0]     out_port,
  output logic                 irq
);

  localparam logic [2:0] ADDR_DATA_OUT = 3'd0;
  localparam logic [2:0] ADDR_DATA_IN  = 3'd1;
  localparam logic [2:0] ADDR_IRQ_MASK = 3'd2;
  localparam logic [2:0] ADDR_EDGE_CAP = 3'd3;
  localparam logic [2:0] ADDR_OUTSET   = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR   = 3'd5;
  localparam logic [2:0] ARM_MAX       = 3'(SYNC_STAGES + 1);

  logic             wr;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] data_out;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_cap;
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] det;
  logic [WIDTH-1:0] clr;
  logic [2:0]       arm_cnt;
  logic             arm;
  logic [31:0]      rdata;
  logic             unused_wdata;

  assign wr           = bus.chipselect & ~bus.write_n;
  assign wdata        = bus.writedata[WIDTH-1:0];
  assign unused_wdata = ^bus.writedata;
  assign sync         = sync_q[SYNC_STAGES-1];
  assign arm          = (arm_cnt == ARM_MAX);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would let later statements see updated values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out <= RESET_VALUE[WIDTH-1:0];
      irq_mask <= '0;
    end else if (wr) begin
      case (bus.address)
        ADDR_DATA_OUT: data_out <= wdata;
        ADDR_IRQ_MASK: irq_mask <= wdata;
        ADDR_OUTSET:   data_out <= data_out | wdata;
        ADDR_OUTCLR:   data_out <= data_out & ~wdata;
        default:       ;
      endcase
    end
  end

  // NOTE: the synchroniser array is reset element by element; an unreset array
  // would leave sync/prev undefined at release and could fake an edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev <= '0;
    end else begin
      sync_q[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev <= sync;
    end
  end

  // Holds edge detection off until the synchroniser and prev hold real input values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      arm_cnt <= '0;
    else if (!arm)     arm_cnt <= arm_cnt + 3'd1;
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    det = '0;
    if (arm) begin
      case (EDGE_TYPE)
        1:       det = ~sync & prev;
        2:       det = sync ^ prev;
        default: det = sync & ~prev;
      endcase
    end
  end

  assign clr = (wr && bus.address == ADDR_EDGE_CAP) ? wdata : '0;

  // A new edge overrides a same-cycle clear so no event is ever dropped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) edge_cap <= '0;
    else          edge_cap <= (edge_cap & ~clr) | det;
  end

  always_comb begin
    rdata = '0;
    case (bus.address)
      ADDR_DATA_OUT: rdata[WIDTH-1:0] = data_out;
      ADDR_DATA_IN:  rdata[WIDTH-1:0] = sync;
      ADDR_IRQ_MASK: rdata[WIDTH-1:0] = irq_mask;
      ADDR_EDGE_CAP: rdata[WIDTH-1:0] = edge_cap;
      default:       rdata = '0;
    endcase
  end

  assign bus.readdata = rdata;
  assign out_port     = data_out;
  assign irq          = |(edge_cap & irq_mask);

endmodule

// File: tb/tb_platform_pio_gpio.sv
// Directed bench for platform_pio_gpio: one rising-edge instance and one any-edge
// instance with a non-zero output reset value.
module tb_platform_pio_gpio;

  logic       clk;
  logic       reset_n;
  logic [7:0] in0, in2;
  logic [7:0] out0, out2;
  logic       irq0, irq2;
  logic [31:0] rd;
  int total = 0;
  int bad   = 0;

  platform_pio_gpio_if bus0 ();
  platform_pio_gpio_if bus2 ();

  platform_pio_gpio #(.WIDTH(8), .RESET_VALUE(32'h0), .EDGE_TYPE(0), .SYNC_STAGES(2)) dut0 (
    .clk(clk), .reset_n(reset_n), .bus(bus0), .in_port(in0), .out_port(out0), .irq(irq0)
  );

  platform_pio_gpio #(.WIDTH(8), .RESET_VALUE(32'h5A), .EDGE_TYPE(2), .SYNC_STAGES(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .bus(bus2), .in_port(in2), .out_port(out2), .irq(irq2)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_idle();
    bus0.chipselect = 1'b0; bus0.write_n = 1'b1; bus0.address = 3'd0; bus0.writedata = '0;
    bus2.chipselect = 1'b0; bus2.write_n = 1'b1; bus2.address = 3'd0; bus2.writedata = '0;
  endtask

  task automatic bus_write(input int sel, input logic [2:0] addr, input logic [31:0] data);
    if (sel == 0) begin
      bus0.address = addr; bus0.chipselect = 1'b1; bus0.write_n = 1'b0; bus0.writedata = data;
    end else begin
      bus2.address = addr; bus2.chipselect = 1'b1; bus2.write_n = 1'b0; bus2.writedata = data;
    end
    tick();
    bus_idle();
  endtask

  task automatic bus_read(input int sel, input logic [2:0] addr, output logic [31:0] data);
    if (sel == 0) begin
      bus0.address = addr; bus0.chipselect = 1'b1; bus0.write_n = 1'b1;
    end else begin
      bus2.address = addr; bus2.chipselect = 1'b1; bus2.write_n = 1'b1;
    end
    #1;
    data = (sel == 0) ? bus0.readdata : bus2.readdata;
    bus_idle();
  endtask

  initial begin
    reset_n = 1'b0;
    in0 = 8'hFF;
    in2 = 8'h00;
    bus_idle();

    tick(3);
    check("rst_out0", {24'h0, out0}, 32'h00);
    check("rst_out2", {24'h0, out2}, 32'h5A);
    check("rst_irq0", {31'h0, irq0}, 32'h0);

    reset_n = 1'b1;
    tick(10);
    check("arm_out0", {24'h0, out0}, 32'h00);
    bus_read(0, 3'd3, rd); check("arm_edgecap", rd, 32'h00);
    check("arm_irq0", {31'h0, irq0}, 32'h0);
    bus_read(0, 3'd1, rd); check("arm_datain", rd, 32'hFF);

    // Output register and set/clear aliases
    bus_write(0, 3'd0, 32'h0000_00A5); check("out_a5", {24'h0, out0}, 32'hA5);
    bus_write(0, 3'd4, 32'h0000_000A); check("out_set", {24'h0, out0}, 32'hAF);
    bus_write(0, 3'd5, 32'h0000_0081); check("out_clr", {24'h0, out0}, 32'h2E);
    bus_read(0, 3'd0, rd); check("rd_dataout", rd, 32'h2E);
    bus_read(0, 3'd4, rd); check("rd_outset", rd, 32'h0);
    bus_read(0, 3'd5, rd); check("rd_outclr", rd, 32'h0);
    bus_write(0, 3'd6, 32'hFFFF_FFFF);
    bus_read(0, 3'd6, rd); check("rd_resv6", rd, 32'h0);
    bus_read(0, 3'd0, rd); check("resv_noeffect", rd, 32'h2E);
    bus_write(0, 3'd0, 32'hFFFF_FF12);
    bus_read(0, 3'd0, rd); check("upper_ignored", rd, 32'h12);

    // Falling edges are not captured in rising mode
    in0 = 8'h00;
    tick(4);
    bus_read(0, 3'd3, rd); check("fall_ignored", rd, 32'h00);

    // Rising edge on bit3: sampled at edge k
    in0 = 8'h08;
    tick();
    bus_read(0, 3'd1, rd); check("datain_k", rd, 32'h00);
    tick();
    bus_read(0, 3'd1, rd); check("datain_k1", rd, 32'h08);
    bus_read(0, 3'd3, rd); check("edgecap_k1", rd, 32'h00);
    tick();
    bus_read(0, 3'd3, rd); check("edgecap_k2", rd, 32'h08);
    check("irq_masked", {31'h0, irq0}, 32'h0);
    bus_write(0, 3'd2, 32'h0000_0008);
    check("irq_unmask", {31'h0, irq0}, 32'h1);
    bus_read(0, 3'd2, rd); check("rd_mask", rd, 32'h08);

    // Clear collides with a fresh rising edge on bit3: set wins
    in0 = 8'h00;
    tick(3);
    in0 = 8'h08;
    tick(2);
    bus_write(0, 3'd3, 32'h0000_0008);
    bus_read(0, 3'd3, rd); check("set_wins", rd, 32'h08);
    check("set_wins_irq", {31'h0, irq0}, 32'h1);
    bus_write(0, 3'd3, 32'h0000_0008);
    bus_read(0, 3'd3, rd); check("w1c_clear", rd, 32'h00);
    check("w1c_irq", {31'h0, irq0}, 32'h0);

    // Fill edge_cap, then reset asynchronously mid-cycle
    bus_write(0, 3'd0, 32'h0000_003C);
    in0 = 8'h00;
    tick(3);
    in0 = 8'hFF;
    tick(3);
    bus_write(0, 3'd2, 32'h0000_00FF);
    bus_read(0, 3'd3, rd); check("pre_rst_cap", rd, 32'hFF);
    check("pre_rst_out", {24'h0, out0}, 32'h3C);
    check("pre_rst_irq", {31'h0, irq0}, 32'h1);
    #5;
    reset_n = 1'b0;
    #1;
    check("async_out0", {24'h0, out0}, 32'h00);
    check("async_irq0", {31'h0, irq0}, 32'h0);
    check("async_out2", {24'h0, out2}, 32'h5A);
    bus_read(0, 3'd3, rd); check("async_cap", rd, 32'h00);
    bus_read(0, 3'd2, rd); check("async_mask", rd, 32'h00);
    tick();
    reset_n = 1'b1;
    tick(10);
    bus_read(0, 3'd3, rd); check("rearm_cap", rd, 32'h00);

    // Any-edge instance: rise, clear, then fall sets bit0 again
    in2 = 8'h01;
    tick(3);
    bus_read(1, 3'd3, rd); check("any_rise", rd, 32'h01);
    bus_write(1, 3'd3, 32'h0000_0001);
    in2 = 8'h00;
    bus_read(1, 3'd3, rd); check("any_cleared", rd, 32'h00);
    tick(3);
    bus_read(1, 3'd3, rd); check("any_fall", rd, 32'h01);
    check("any_irq_masked", {31'h0, irq2}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
